// File: rtl/iterate_md5.sv
// rtl/iterate_md5.sv - iterative MD5 compression of one pre-padded 512-bit block, one step per clock
module iterate_md5 (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:511] msg,
  output logic [31:0]  A,
  output logic [31:0]  B,
  output logic [31:0]  C,
  output logic [31:0]  D,
  output logic         done
);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  typedef enum logic [1:0] {S_RUN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic         step_en, load_out;
  logic [0:511] msg_q;
  logic [31:0]  a, b, c, d;
  logic [6:0]   cnt;

  logic [5:0]   idx;
  logic [3:0]   i4, g;
  logic [4:0]   sh;
  logic [31:0]  f, mg, sum, rot, tmp;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    step_en  = 1'b0;
    load_out = 1'b0;
    case (state_q)
      S_RUN: begin
        if (cnt == 7'd64) begin
          load_out = 1'b1;
          state_d  = S_DONE;
        end else begin
          step_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Index arithmetic is done in 4 bits: the mod-16 wrap of g comes for free.
  always_comb begin
    idx = cnt[5:0];
    i4  = idx[3:0];
    f   = '0;
    g   = '0;
    case (idx[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = i4;                 end
      2'd1: begin f = (d & b) | (~d & c); g = i4 * 4'd5 + 4'd1;   end
      2'd2: begin f = b ^ c ^ d;          g = i4 * 4'd3 + 4'd5;   end
      default: begin f = c ^ (b | ~d);    g = i4 * 4'd7;          end
    endcase
    case ({idx[5:4], idx[1:0]})
      4'd0:  sh = 5'd7;   4'd1:  sh = 5'd12;  4'd2:  sh = 5'd17;  4'd3:  sh = 5'd22;
      4'd4:  sh = 5'd5;   4'd5:  sh = 5'd9;   4'd6:  sh = 5'd14;  4'd7:  sh = 5'd20;
      4'd8:  sh = 5'd4;   4'd9:  sh = 5'd11;  4'd10: sh = 5'd16;  4'd11: sh = 5'd23;
      4'd12: sh = 5'd6;   4'd13: sh = 5'd10;  4'd14: sh = 5'd15;  default: sh = 5'd21;
    endcase
    // Word g sits at bit offset (15-g)*32, and 15-g is just ~g in four bits.
    mg  = msg_q[{~g, 5'd0} +: 32];
    sum = a + f + K[idx] + mg;
    rot = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));
    tmp = b + rot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q <= msg;
      a     <= IV_A;
      b     <= IV_B;
      c     <= IV_C;
      d     <= IV_D;
      cnt   <= '0;
      A     <= '0;
      B     <= '0;
      C     <= '0;
      D     <= '0;
      done  <= 1'b0;
    end else begin
      if (step_en) begin
        a   <= d;
        d   <= c;
        c   <= b;
        b   <= tmp;
        cnt <= cnt + 7'd1;
      end
      if (load_out) begin
        A    <= IV_A + a;
        B    <= IV_B + b;
        C    <= IV_C + c;
        D    <= IV_D + d;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iterate_md5.sv
// tb/tb_iterate_md5.sv - known-answer, randomized and reset-corner checks for iterate_md5
module tb_iterate_md5;

  logic         clk;
  logic         rst;
  logic [0:511] msg;
  logic [31:0]  A, B, C, D;
  logic         done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] kt [64];
  int          sh_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  typedef struct {
    string        nm;
    logic [0:511] blk;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [3];

  iterate_md5 dut (
    .clk  (clk),
    .rst  (rst),
    .msg  (msg),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:511] mk_blk(input logic [31:0] m0, input logic [31:0] m1,
                                          input logic [31:0] m14);
    logic [0:511] blk;
    blk = '0;
    blk[15*32 +: 32] = m0;
    blk[14*32 +: 32] = m1;
    blk[1*32 +: 32]  = m14;
    return blk;
  endfunction

  function automatic logic [127:0] md5_ref(input logic [0:511] blk);
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t, sum;
    int g, s;
    for (int i = 0; i < 16; i++) m[i] = blk[(15 - i) * 32 +: 32];
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      s   = sh_tab[(i / 16) * 4 + (i % 4)];
      sum = a + f + kt[i] + m[g];
      t   = b + ((sum << s) | (sum >> (32 - s)));
      a = d; d = c; c = b; b = t;
    end
    return {32'h67452301 + a, 32'hefcdab89 + b, 32'h98badcfe + c, 32'h10325476 + d};
  endfunction

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reset with blk latched, release, then watch all 65 edges and the hold period.
  task automatic apply(input string nm, input logic [0:511] blk, input logic [127:0] exp,
                       input int hold);
    logic [128:0] early, held;
    bit           early_seen, held_seen;
    msg = blk;
    rst = 1'b1;
    @(negedge clk);
    chk({nm, " reset"}, {A, B, C, D, done}, '0);
    @(negedge clk);
    rst = 1'b0;
    early_seen = 0;
    early = '0;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 10) msg = ~blk;
      if (k < 65 && !early_seen && {A, B, C, D, done} !== '0) begin
        early_seen = 1;
        early = {A, B, C, D, done};
      end
    end
    chk({nm, " early"}, early, '0);
    chk({nm, " digest"}, {A, B, C, D, done}, {exp, 1'b1});
    held_seen = 0;
    held = {exp, 1'b1};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!held_seen && {A, B, C, D, done} !== {exp, 1'b1}) begin
        held_seen = 1;
        held = {A, B, C, D, done};
      end
    end
    chk({nm, " hold"}, held, {exp, 1'b1});
  endtask

  initial begin
    logic [0:511] rblk;
    real r;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end

    vecs[0] = '{"zzzzzz", mk_blk(32'h7a7a7a7a, 32'h00807a7a, 32'h00000030),
                128'hd2413e45_cc71e018_991c2dfb_6a9023ce};
    vecs[1] = '{"empty", mk_blk(32'h00000080, 32'h0, 32'h0),
                128'hd98c1dd4_04b2008f_980980e9_7e42f8ec};
    vecs[2] = '{"abc", mk_blk(32'h80636261, 32'h0, 32'h00000018),
                128'h98500190_b04fd23c_7d3f96d6_727fe128};

    rst = 1'b1;
    msg = '0;
    @(negedge clk);

    for (int v = 0; v < 3; v++)
      apply(vecs[v].nm, vecs[v].blk, vecs[v].exp, (v == 0) ? 100 : 5);

    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 16; w++) rblk[w * 32 +: 32] = $urandom;
      apply($sformatf("rand%0d", n), rblk, md5_ref(rblk), 3);
    end

    // Abort a computation at cycle 30 and restart on the "abc" block.
    for (int w = 0; w < 16; w++) rblk[w * 32 +: 32] = $urandom;
    msg = rblk;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    apply("midreset_abc", vecs[2].blk, vecs[2].exp, 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
